ibex_fetch_req_ctrl: RTL and testbench

Instruction-bus request controller sitting directly upstream of the fetch FIFO in the IF stage. Issues word-aligned OBI-style requests on the instruction bus and tracks up to NUM_REQS outstanding responses. Forwards in-order responses into the FIFO's push port and drops responses belonging to fetches made stale by a branch. Throttles itself on the FIFO's per-entry busy vector.

---
 rtl/ibex_fetch_req_ctrl.sv | 119 +++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-bus request controller for the IF stage: issues word-aligned fetches,
// tracks outstanding responses and pushes the in-order, non-stale ones into the fetch FIFO.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    logic [29:0]         fetch_addr_q, fetch_addr_d;
    logic [29:0]         pend_addr_q, pend_addr_d;
    logic                pend_q, pend_d;
    logic                pend_stale_q, pend_stale_d;
    logic [NUM_REQS-1:0] outst_q, outst_d, outst_shift;
    logic [NUM_REQS-1:0] discard_q, discard_d, discard_shift;
    logic [NUM_REQS-1:0] new_slot;

    logic        fifo_ready;
    logic        can_issue;
    logic        rsp;
    logic        gnt;
    logic        grant_stale;
    logic [29:0] target;
    logic [29:0] next_addr;
    logic [29:0] req_addr;

    assign target     = branch_addr_i[31:2];
    assign fifo_ready = ~&fifo_busy_i;
    assign rsp        = instr_rvalid_i & outst_q[0];

    // A response retiring this cycle frees its slot for a same-cycle request.
    assign can_issue  = req_i & fifo_ready & (~outst_q[NUM_REQS-1] | rsp);

    assign next_addr  = branch_i ? target : fetch_addr_q;
    assign req_addr   = pend_q ? pend_addr_q : next_addr;

    assign instr_req_o  = ~rst_i & (pend_q | can_issue);
    assign instr_addr_o = {req_addr, 2'b00};
    assign gnt          = instr_req_o & instr_gnt_i;

    // A held request is stale once any branch has been seen while it waited.
    assign grant_stale  = pend_q & (pend_stale_q | branch_i);

    assign fifo_clear_o = ~rst_i & branch_i;
    assign fifo_addr_o  = {branch_addr_i[31:1], 1'b0};
    assign fifo_valid_o = ~rst_i & rsp & ~discard_q[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign busy_o       = instr_req_o | (~rst_i & outst_q[0]);

    assign outst_shift   = rsp ? (outst_q >> 1) : outst_q;
    assign discard_shift = rsp ? (discard_q >> 1) : discard_q;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
        if (i == 0) begin : g_first
            assign new_slot[i] = gnt & ~outst_shift[i];
        end else begin : g_rest
            assign new_slot[i] = gnt & ~outst_shift[i] & outst_shift[i-1];
        end
        assign outst_d[i]   = outst_shift[i] | new_slot[i];
        assign discard_d[i] = (outst_shift[i] & (discard_shift[i] | branch_i))
                            | (new_slot[i] & grant_stale);
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_stale_d = pend_q & ~gnt & (pend_stale_q | branch_i);

        if (branch_i) begin
            fetch_addr_d = target + {29'd0, gnt & ~pend_q};
        end else if (gnt && !(pend_q && pend_stale_q)) begin
            fetch_addr_d = fetch_addr_q + 30'd1;
        end

        if (gnt) begin
            pend_d = 1'b0;
        end else if (instr_req_o) begin
            pend_d      = 1'b1;
            pend_addr_d = req_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q <= '0;
            pend_addr_q  <= '0;
            pend_q       <= 1'b0;
            pend_stale_q <= 1'b0;
            outst_q      <= '0;
            discard_q    <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_q       <= pend_d;
            pend_stale_q <= pend_stale_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
        end
    end

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed self-checking bench for ibex_fetch_req_ctrl with NUM_REQS=2.
module tb_ibex_fetch_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        branch;
    logic [31:0] branch_addr;
    logic [1:0]  fifo_busy;
    logic        fifo_clear;
    logic        fifo_valid;
    logic [31:0] fifo_addr;
    logic [31:0] fifo_rdata;
    logic        fifo_err;
    logic        busy;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .branch_i       (branch),
        .branch_addr_i  (branch_addr),
        .fifo_busy_i    (fifo_busy),
        .fifo_clear_o   (fifo_clear),
        .fifo_valid_o   (fifo_valid),
        .fifo_addr_o    (fifo_addr),
        .fifo_rdata_o   (fifo_rdata),
        .fifo_err_o     (fifo_err),
        .busy_o         (busy),
        .instr_req_o    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_addr_o   (instr_addr),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .instr_err_i    (instr_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
    task automatic applyStimulus(input logic r, input logic br, input logic [31:0] ba,
                                 input logic [1:0] fb, input logic g, input logic rv,
                                 input logic [31:0] rd, input logic er);
        req          = r;
        branch       = br;
        branch_addr  = ba;
        fifo_busy    = fb;
        instr_gnt    = g;
        instr_rvalid = rv;
        instr_rdata  = rd;
        instr_err    = er;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        step();
        step();

        applyStimulus(1, 1, 32'h40, 2'b00, 1, 1, 32'h0, 0);
        checkOutput("rst_req", instr_req, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_clear", fifo_clear, 1'b0);
        checkOutput("rst_valid", fifo_valid, 1'b0);
        step();
        rst = 1'b0;

        // Streaming fetch: grant every cycle, response one cycle later
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("seq_addr0", instr_addr, 32'h0);
        checkOutput("seq_req0", instr_req, 1'b1);
        checkOutput("seq_valid0", fifo_valid, 1'b0);
        step();
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'h13, 0);
        checkOutput("seq_addr1", instr_addr, 32'h4);
        checkOutput("seq_valid1", fifo_valid, 1'b1);
        checkOutput("seq_rdata1", fifo_rdata, 32'h13);
        step();
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'h13, 0);
        checkOutput("seq_addr2", instr_addr, 32'h8);
        checkOutput("seq_valid2", fifo_valid, 1'b1);
        step();
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h13, 0);
        checkOutput("drain_req", instr_req, 1'b0);
        checkOutput("drain_valid", fifo_valid, 1'b1);
        checkOutput("drain_busy", busy, 1'b1);
        step();
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("idle_busy", busy, 1'b0);

        // Held request across a branch: address stable, response dropped
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("hold_addr0", instr_addr, 32'hC);
        step();
        applyStimulus(1, 1, 32'h100, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("hold_addr_br", instr_addr, 32'hC);
        checkOutput("hold_clear", fifo_clear, 1'b1);
        step();
        applyStimulus(0, 0, 32'h100, 2'b11, 0, 0, 32'h0, 0);
        checkOutput("hold_req", instr_req, 1'b1);
        checkOutput("hold_addr2", instr_addr, 32'hC);
        step();
        applyStimulus(1, 0, 32'h100, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("hold_addr_gnt", instr_addr, 32'hC);
        step();
        applyStimulus(1, 0, 32'h100, 2'b00, 1, 1, 32'hDEAD, 0);
        checkOutput("stale_drop", fifo_valid, 1'b0);
        checkOutput("after_br_addr", instr_addr, 32'h100);
        step();
        applyStimulus(0, 0, 32'h100, 2'b00, 0, 1, 32'hABCD, 0);
        checkOutput("new_push", fifo_valid, 1'b1);
        checkOutput("new_rdata", fifo_rdata, 32'hABCD);
        step();

        // Branch with two outstanding, full capacity
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("fill_addr0", instr_addr, 32'h104);
        step();
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("fill_addr1", instr_addr, 32'h108);
        step();
        applyStimulus(1, 1, 32'h203, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("full_req", instr_req, 1'b0);
        checkOutput("br_clear", fifo_clear, 1'b1);
        checkOutput("br_fifo_addr", fifo_addr, 32'h202);
        step();
        applyStimulus(1, 0, 32'h203, 2'b00, 1, 1, 32'h55, 0);
        checkOutput("old0_drop", fifo_valid, 1'b0);
        checkOutput("freed_req", instr_req, 1'b1);
        checkOutput("target_addr", instr_addr, 32'h200);
        step();
        applyStimulus(0, 0, 32'h203, 2'b00, 0, 1, 32'h66, 0);
        checkOutput("old1_drop", fifo_valid, 1'b0);
        step();
        applyStimulus(0, 0, 32'h203, 2'b00, 0, 1, 32'h77, 1);
        checkOutput("target_push", fifo_valid, 1'b1);
        checkOutput("target_rdata", fifo_rdata, 32'h77);
        checkOutput("target_err", fifo_err, 1'b1);
        step();

        // FIFO throttling, and a held request that ignores throttling
        applyStimulus(1, 0, 32'h0, 2'b11, 1, 0, 32'h0, 0);
        checkOutput("fifo_full_req", instr_req, 1'b0);
        checkOutput("fifo_full_busy", busy, 1'b0);
        applyStimulus(1, 0, 32'h0, 2'b01, 1, 0, 32'h0, 0);
        checkOutput("fifo_ok_req", instr_req, 1'b1);
        checkOutput("fifo_ok_addr", instr_addr, 32'h204);
        step();
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("pend_addr", instr_addr, 32'h208);
        step();
        applyStimulus(0, 0, 32'h0, 2'b11, 0, 0, 32'h0, 0);
        checkOutput("pend_hold_req", instr_req, 1'b1);
        checkOutput("pend_hold_addr", instr_addr, 32'h208);
        step();
        applyStimulus(0, 0, 32'h0, 2'b11, 1, 0, 32'h0, 0);
        step();

        // Reset with two outstanding; late response must be ignored
        rst = 1'b1;
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("mid_rst_req", instr_req, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h99, 0);
        checkOutput("late_rvalid", fifo_valid, 1'b0);
        checkOutput("late_busy", busy, 1'b0);
        step();
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("post_rst_addr", instr_addr, 32'h0);
        step();

        // Branch to the top word with grant: next fetch wraps to zero
        applyStimulus(1, 1, 32'hFFFF_FFFC, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("wrap_top", instr_addr, 32'hFFFF_FFFC);
        step();
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 1, 32'h1, 0);
        checkOutput("wrap_valid", fifo_valid, 1'b0);
        checkOutput("wrap_addr", instr_addr, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
